rv_divide: RTL and testbench
============================

Name: rv_divide

Overview:
Iterative 32-bit divider implementing RV32M DIV, DIVU, REM and REMU. It sits in the execute stage beside the multiplier and takes the same decoded operands (rs1, rs2, funct3). It produces a 32-bit rd result for the writeback stage and asserts busy so that the pipeline control can stall. It uses a radix-2 restoring algorithm on operand magnitudes, followed by a sign fix-up.

Parameters:
g_fast_special, 1, 1 = divide-by-zero and signed-overflow cases bypass iteration (short latency); 0 = same results, full latency

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low (0 = reset)
start_i  in  1  request; sampled only when busy_o=0
kill_i  in  1  abort current operation (pipeline flush)
x_stall_i  in  1  downstream stall; holds a completed result
d_rs1_i  in  32  dividend
d_rs2_i  in  32  divisor
d_fun_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
busy_o  out  1  operation accepted and result not yet consumed
done_o  out  1  rd_o valid
w_rd_o  out  32  quotient or remainder

Behaviour:
- Reset (rst_i=0, async): state IDLE, busy_o=0, done_o=0, w_rd_o=0, all datapath registers cleared. Reset mid-operation discards the operation; no done_o follows.
- States:
  - IDLE: start_i=1 and kill_i=0 -> PREP; operands and funct3 latched.
  - PREP (1 cycle):
    - Computes magnitudes for signed ops and records sign_q = sign(rs1) xor sign(rs2) and sign_r = sign(rs1).
    - Special case and g_fast_special=1 -> DONE.
    - Otherwise -> DIV with counter=31.
  - DIV (32 cycles): one restoring step per cycle. Partial remainder is 33 bits; trial = {rem[31:0], q[31]} - divisor. If non-negative, keep it and shift in quotient bit 1. Counter decrements; at 0 -> FIX.
  - FIX (1 cycle): negate quotient if sign_q, negate remainder if sign_r (signed ops only). Special-case override applies here when g_fast_special=0. Select quotient or remainder by funct3[1]. -> DONE.
  - DONE: done_o=1, w_rd_o stable. If x_stall_i=0 -> IDLE (done_o low next cycle). If x_stall_i=1 -> remain in DONE.
- busy_o=1 in PREP, DIV, FIX and DONE.
- Latency, counted from the start_i sampling edge:
  - Normal operation: done_o first high in cycle 35 (PREP 1 + DIV 32 + FIX 1, then DONE).
  - Fast special case: done_o first high in cycle 2.
- Special cases (RISC-V defined):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = rs1, for both signed and unsigned.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- start_i while busy_o=1 is ignored; there is no queueing.
- kill_i=1 in any non-IDLE state -> IDLE on the next edge, busy_o=0 and done_o=0 there. kill_i together with start_i in IDLE: start is ignored.
- w_rd_o holds its last value in IDLE and updates only on entry to DONE.
- x_stall_i does not freeze iteration in PREP, DIV or FIX.

Decomposition:
- Shared defs file (rv_defs): funct3 constants (DIV, DIVU, REM, REMU) and the state encoding constants (IDLE, PREP, DIV, FIX, DONE).
- No sub-module. The single restoring step is inline. Sign conditioning and negation use one shared 32-bit negate, time-multiplexed between PREP and FIX.

Test Plan:
- DIV 7 / 0xFFFFFFFE (-2) -> w_rd_o=0xFFFFFFFD, done_o exactly 35 cycles after start, busy_o high cycles 1..35.
- REM 0xFFFFFFF9 (-7) % 2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9 % 2 -> 0x00000001; DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF.
- Divide by zero, g_fast_special=1:
  - DIVU 0x1234 / 0 -> 0xFFFFFFFF; REM 0x1234 % 0 -> 0x1234; done_o at cycle 2.
  - With g_fast_special=0: same values at cycle 35.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
- Abort and reset:
  - kill_i pulsed in DIV cycle 10 -> busy_o=0 next cycle, no done_o. Immediate new DIVU 100 / 7 -> 14 with full latency.
  - rst_i low mid-DIV -> all outputs 0 asynchronously.
- Stall and ignored start: x_stall_i=1 for 5 cycles on completion -> done_o and w_rd_o held stable for 6 cycles, IDLE after release. A start_i pulse during busy_o=1 yields no extra result.

Source files
------------

// File: rtl/rv_divide_pkg.sv
// rv_divide_pkg: funct3 codes, FSM state encoding and special-case helpers for rv_divide
package rv_divide_pkg;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic logic is_signed_op(input logic [2:0] fun);
        return fun == F_DIV || fun == F_REM;
    endfunction

    // Divide-by-zero, or the one signed quotient that does not fit in 32 bits
    function automatic logic is_special(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        return b == '0 || (is_signed_op(fun) && a == 32'h8000_0000 && b == '1);
    endfunction

endpackage

// File: rtl/rv_divide_if.sv
// rv_divide_if: execute-stage request/response bundle between pipeline control and the divider
interface rv_divide_if;

    logic        start_i;
    logic        kill_i;
    logic        x_stall_i;
    logic [31:0] d_rs1_i;
    logic [31:0] d_rs2_i;
    logic [2:0]  d_fun_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] w_rd_o;

    modport master (
        output start_i, kill_i, x_stall_i, d_rs1_i, d_rs2_i, d_fun_i,
        input  busy_o, done_o, w_rd_o
    );

    modport slave (
        input  start_i, kill_i, x_stall_i, d_rs1_i, d_rs2_i, d_fun_i,
        output busy_o, done_o, w_rd_o
    );

endinterface

// File: rtl/rv_divide.sv
// rv_divide: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Divides magnitudes over 32 cycles, then fixes signs with a single shared negator.
module rv_divide
    import rv_divide_pkg::*;
#(
    parameter bit g_fast_special = 1'b1
) (
    input logic        clk_i,
    input logic        rst_i,
    rv_divide_if.slave dif
);

    logic [2:0]  state_q, state_d;
    logic [2:0]  fun_q, fun_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] rd_q, rd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    logic        sgn;
    logic        special;
    logic        neg_sel;
    logic [33:0] x;
    logic [33:0] trial;
    logic [31:0] res;
    logic [31:0] neg_in;
    logic [31:0] neg_out;
    logic [31:0] spec_res;

    // A negative signed divisor is added rather than negated, so the negator stays free
    always_comb begin
        sgn      = is_signed_op(fun_q);
        special  = is_special(fun_q, a_q, b_q);
        x        = {rem_q, quo_q[31]};
        trial    = (sgn && b_q[31]) ? x + {2'b11, b_q} : x - {2'b00, b_q};
        res      = fun_q[1] ? rem_q[31:0] : quo_q;
        neg_sel  = fun_q[1] ? rneg_q : qneg_q;
        neg_in   = (state_q == S_PREP) ? a_q : res;
        neg_out  = 32'd0 - neg_in;
        spec_res = fun_q[1] ? (b_q == '0 ? a_q : 32'h0) : (b_q == '0 ? 32'hFFFF_FFFF : 32'h8000_0000);
    end

    always_comb begin
        state_d = state_q;
        fun_d   = fun_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            S_IDLE: if (dif.start_i && !dif.kill_i) begin
                state_d = S_PREP;
                fun_d   = dif.d_fun_i;
                a_d     = dif.d_rs1_i;
                b_d     = dif.d_rs2_i;
            end
            S_PREP: begin
                quo_d   = (sgn && a_q[31]) ? neg_out : a_q;
                rem_d   = '0;
                cnt_d   = 5'd31;
                qneg_d  = sgn && (a_q[31] ^ b_q[31]);
                rneg_d  = sgn && a_q[31];
                state_d = (g_fast_special && special) ? S_DONE : S_DIV;
                rd_d    = (g_fast_special && special) ? spec_res : rd_q;
            end
            S_DIV: begin
                rem_d   = trial[33] ? x[32:0] : trial[32:0];
                quo_d   = {quo_q[30:0], ~trial[33]};
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == '0) ? S_FIX : S_DIV;
            end
            S_FIX: begin
                rd_d    = special ? spec_res : (neg_sel ? neg_out : res);
                state_d = S_DONE;
            end
            S_DONE: state_d = dif.x_stall_i ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A flush wins over everything, including a result about to be written
        if (state_q != S_IDLE && dif.kill_i) begin
            state_d = S_IDLE;
            rd_d    = rd_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            fun_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fun_q   <= fun_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign dif.busy_o = state_q != S_IDLE;
    assign dif.done_o = state_q == S_DONE;
    assign dif.w_rd_o = rd_q;

endmodule

// File: tb/tb_rv_divide.sv
// tb_rv_divide: directed vectors against a fast-special and a full-latency rv_divide driven in lockstep
module tb_rv_divide;
    import rv_divide_pkg::*;

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          sp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  fun = F_DIV;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    int          checks = 0;
    int          failures = 0;
    vec_t        vt[$];

    rv_divide_if dif_f();
    rv_divide_if dif_s();

    assign dif_f.start_i   = start;
    assign dif_f.kill_i    = kill;
    assign dif_f.x_stall_i = stall;
    assign dif_f.d_rs1_i   = rs1;
    assign dif_f.d_rs2_i   = rs2;
    assign dif_f.d_fun_i   = fun;
    assign dif_s.start_i   = start;
    assign dif_s.kill_i    = kill;
    assign dif_s.x_stall_i = stall;
    assign dif_s.d_rs1_i   = rs1;
    assign dif_s.d_rs2_i   = rs2;
    assign dif_s.d_fun_i   = fun;

    rv_divide #(.g_fast_special(1'b1)) dut_f (.clk_i(clk), .rst_i(rst_n), .dif(dif_f));
    rv_divide #(.g_fast_special(1'b0)) dut_s (.clk_i(clk), .rst_i(rst_n), .dif(dif_s));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Called on a falling edge; start is sampled by the next rising edge (cycle 0)
    task automatic run(input int id, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat_f);
        int          df = 0;
        int          ds = 0;
        int          nf = 0;
        int          ns = 0;
        int          busy_bad = 0;
        logic [31:0] rf = '0;
        logic [31:0] rsv = '0;
        start = 1'b1;
        fun   = f;
        rs1   = a;
        rs2   = b;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (dif_f.done_o) begin
                nf++;
                if (df == 0) begin df = n; rf = dif_f.w_rd_o; end
            end
            if (dif_s.done_o) begin
                ns++;
                if (ds == 0) begin ds = n; rsv = dif_s.w_rd_o; end
            end
            if (dif_f.busy_o !== (n <= lat_f) || dif_s.busy_o !== (n <= 35)) busy_bad++;
        end
        chk($sformatf("v%0d lat_fast", id), df, lat_f);
        chk($sformatf("v%0d lat_full", id), ds, 35);
        chk($sformatf("v%0d rd_fast", id), rf, exp);
        chk($sformatf("v%0d rd_full", id), rsv, exp);
        chk($sformatf("v%0d done_cycles_fast", id), nf, 1);
        chk($sformatf("v%0d done_cycles_full", id), ns, 1);
        chk($sformatf("v%0d busy_window", id), busy_bad, 0);
        chk($sformatf("v%0d hold_idle", id), dif_s.w_rd_o, exp);
    endtask

    initial begin
        int          dcnt;
        int          first_f;
        int          first_s;
        int          cnt_f;
        int          cnt_s;
        int          bad;
        vt.push_back('{F_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
        vt.push_back('{F_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0});
        vt.push_back('{F_REMU, 32'hFFFF_FFF9,  32'd2,         32'h0000_0001, 1'b0});
        vt.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 1'b0});
        vt.push_back('{F_DIVU, 32'h1234,       32'd0,         32'hFFFF_FFFF, 1'b1});
        vt.push_back('{F_REM,  32'h1234,       32'd0,         32'h0000_1234, 1'b1});
        vt.push_back('{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vt.push_back('{F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vt.push_back('{F_DIV,  32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b1});
        vt.push_back('{F_REMU, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1});
        vt.push_back('{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vt.push_back('{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
        vt.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'h8000_0001, 32'h0000_0001, 1'b0});
        vt.push_back('{F_REMU, 32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE, 1'b0});
        vt.push_back('{F_DIV,  32'h8000_0000,  32'h8000_0000, 32'h0000_0001, 1'b0});
        vt.push_back('{F_REM,  32'h8000_0001,  32'h8000_0000, 32'h8000_0001, 1'b0});
        vt.push_back('{F_DIV,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0});
        vt.push_back('{F_REM,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 1'b0});
        vt.push_back('{F_REM,  32'd100,        32'hFFFF_FFF9, 32'h0000_0002, 1'b0});
        vt.push_back('{F_DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0});
        vt.push_back('{F_REMU, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vt.push_back('{F_DIV,  32'd0,          32'd5,         32'h0000_0000, 1'b0});

        repeat (2) @(negedge clk);
        chk("reset busy_fast", dif_f.busy_o, 0);
        chk("reset done_fast", dif_f.done_o, 0);
        chk("reset rd_fast", dif_f.w_rd_o, 0);
        chk("reset busy_full", dif_s.busy_o, 0);
        chk("reset done_full", dif_s.done_o, 0);
        chk("reset rd_full", dif_s.w_rd_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) run(i, vt[i].fun, vt[i].a, vt[i].b, vt[i].exp, vt[i].sp ? 2 : 35);

        // Flush in the 10th DIV cycle, then an immediate new request
        start = 1'b1; fun = F_DIVU; rs1 = 32'd1234; rs2 = 32'd5;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill busy_fast", dif_f.busy_o, 0);
        chk("kill busy_full", dif_s.busy_o, 0);
        chk("kill done_fast", dif_f.done_o, 0);
        chk("kill done_full", dif_s.done_o, 0);
        run(100, F_DIVU, 32'd100, 32'd7, 32'd14, 35);

        // Asynchronous reset in the middle of an iteration
        start = 1'b1; fun = F_DIV; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("arst busy_fast", dif_f.busy_o, 0);
        chk("arst busy_full", dif_s.busy_o, 0);
        chk("arst done_full", dif_s.done_o, 0);
        chk("arst rd_fast", dif_f.w_rd_o, 0);
        chk("arst rd_full", dif_s.w_rd_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (dif_f.done_o || dif_s.done_o) dcnt++;
        end
        chk("arst no_done", dcnt, 0);

        // Stall for 5 cycles on completion, plus a start pulse while busy
        first_f = 0; first_s = 0; cnt_f = 0; cnt_s = 0; bad = 0;
        start = 1'b1; fun = F_DIV; rs1 = 32'd7; rs2 = 32'hFFFF_FFFE;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            start = (n == 10);
            if (n == 10) begin fun = F_DIVU; rs1 = 32'd100; rs2 = 32'd7; end
            stall = (n >= 35 && n <= 39);
            if (dif_f.done_o) begin
                cnt_f++;
                if (first_f == 0) first_f = n;
                if (dif_f.w_rd_o !== 32'hFFFF_FFFD) bad++;
            end
            if (dif_s.done_o) begin
                cnt_s++;
                if (first_s == 0) first_s = n;
                if (dif_s.w_rd_o !== 32'hFFFF_FFFD) bad++;
            end
            if (n == 41) begin
                chk("stall release busy_fast", dif_f.busy_o, 0);
                chk("stall release busy_full", dif_s.busy_o, 0);
            end
        end
        chk("stall first_fast", first_f, 35);
        chk("stall first_full", first_s, 35);
        chk("stall done_cycles_fast", cnt_f, 6);
        chk("stall done_cycles_full", cnt_s, 6);
        chk("stall rd_stable", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
